fetch_decode_queue: RTL and testbench

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

---
 rtl/fetch_decode_queue.sv | 81 ++++++++
 tb/tb_fetch_decode_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {instr, pc, pc+4} with
// first-word fall-through head, decode stall, and branch flush from execute.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidF,
    input  logic [31:0]      InstrF,
    input  logic [31:0]      PCF,
    input  logic [31:0]      PCPlus4F,
    output logic             ReadyF,
    input  logic             FlushE,
    input  logic             StallD,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCD,
    output logic [31:0]      PCPlus4D,
    output logic             ValidD,
    output logic [PTR_W:0]   Count,
    output logic             Full,
    output logic             Empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      instrMem   [DEPTH];
    logic [31:0]      pcMem      [DEPTH];
    logic [31:0]      pcPlus4Mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic             push;
    logic             pop;

    assign Full   = (Count == DEPTH_CNT);
    assign Empty  = (Count == '0);
    assign ReadyF = !Full;
    assign ValidD = !Empty;

    assign push = ValidF && ReadyF && !FlushE;
    assign pop  = ValidD && !StallD && !FlushE;

    // Empty queue presents an all-zero NOP bubble to decode.
    assign InstrD   = Empty ? '0 : instrMem[rp];
    assign PCD      = Empty ? '0 : pcMem[rp];
    assign PCPlus4D = Empty ? '0 : pcPlus4Mem[rp];

    // Storage is not reset; it is only observable while Count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wp]   <= InstrF;
            pcMem[wp]      <= PCF;
            pcPlus4Mem[wp] <= PCPlus4F;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            Count <= '0;
        end else if (FlushE) begin
            wp    <= '0;
            rp    <= '0;
            Count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=4).
module tb_fetch_decode_queue;

    logic        clk;
    logic        rst;
    logic        ValidF;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ReadyF;
    logic        FlushE;
    logic        StallD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [2:0]  Count;
    logic        Full;
    logic        Empty;

    int checks = 0;
    int errors = 0;

    fetch_decode_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .ReadyF(ReadyF), .FlushE(FlushE), .StallD(StallD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        ValidF   = v;
        PCF      = pc;
        InstrF   = 32'hA000_0000 | pc;
        PCPlus4F = pc + 32'd4;
    endtask

    task automatic test_reset();
        rst = 1'b0; FlushE = 1'b0; StallD = 1'b0;
        drive(1'b0, 32'd0);
        #12;
        checks++;
        if (Count !== 3'd0 || Empty !== 1'b1 || Full !== 1'b0 || ReadyF !== 1'b1 || ValidD !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got cnt=%0d e=%b f=%b r=%b v=%b exp cnt=0 e=1 f=0 r=1 v=0",
                     Count, Empty, Full, ReadyF, ValidD);
        end
        checks++;
        if (InstrD !== 32'd0 || PCD !== 32'd0 || PCPlus4D !== 32'd0) begin
            errors++;
            $display("FAIL reset_bubble got instr=%h pc=%h pc4=%h exp all 0", InstrD, PCD, PCPlus4D);
        end
        @(negedge clk);
        rst = 1'b1;
        #4;
    endtask

    task automatic test_fill_stalled();
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(4 * i));
            step();
            checks++;
            if (Count !== 3'(i + 1) || PCD !== 32'd0 || ValidD !== 1'b1) begin
                errors++;
                $display("FAIL fill_stalled[%0d] got cnt=%0d pc=%h v=%b exp cnt=%0d pc=0 v=1",
                         i, Count, PCD, ValidD, i + 1);
            end
        end
        checks++;
        if (InstrD !== 32'hA000_0000 || PCPlus4D !== 32'd4) begin
            errors++;
            $display("FAIL fill_head_fields got instr=%h pc4=%h exp a0000000 4", InstrD, PCPlus4D);
        end
    endtask

    task automatic test_full();
        drive(1'b1, 32'd12);
        step();
        checks++;
        if (Count !== 3'd4 || Full !== 1'b1 || ReadyF !== 1'b0 || Empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flags got cnt=%0d f=%b r=%b e=%b exp 4 1 0 0", Count, Full, ReadyF, Empty);
        end
        drive(1'b1, 32'd16);
        step();
        checks++;
        if (Count !== 3'd4 || PCD !== 32'd0) begin
            errors++;
            $display("FAIL full_reject got cnt=%0d pc=%h exp cnt=4 pc=0", Count, PCD);
        end
        drive(1'b0, 32'd0);
        StallD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (PCD !== 32'(4 * i) || InstrD !== (32'hA000_0000 | 32'(4 * i)) || ValidD !== 1'b1) begin
                errors++;
                $display("FAIL drain[%0d] got pc=%h instr=%h v=%b exp pc=%h", i, PCD, InstrD, ValidD, 4 * i);
            end
            step();
        end
        checks++;
        if (Empty !== 1'b1 || InstrD !== 32'd0 || ValidD !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got e=%b instr=%h v=%b exp 1 0 0", Empty, InstrD, ValidD);
        end
    endtask

    task automatic test_stream();
        StallD = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(4 * k));
            step();
            checks++;
            if (Count !== 3'd1 || PCD !== 32'(4 * k) || PCPlus4D !== 32'(4 * k + 4)) begin
                errors++;
                $display("FAIL stream[%0d] got cnt=%0d pc=%h pc4=%h exp cnt=1 pc=%h", k, Count, PCD, PCPlus4D, 4 * k);
            end
        end
        drive(1'b0, 32'd0);
        step();
        checks++;
        if (Empty !== 1'b1 || Count !== 3'd0) begin
            errors++;
            $display("FAIL stream_end got e=%b cnt=%0d exp 1 0", Empty, Count);
        end
    endtask

    task automatic test_flush();
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(200 + 4 * i));
            step();
        end
        checks++;
        if (Count !== 3'd3 || PCD !== 32'd200) begin
            errors++;
            $display("FAIL flush_pre got cnt=%0d pc=%h exp 3 c8", Count, PCD);
        end
        FlushE = 1'b1;
        drive(1'b1, 32'd300);
        step();
        FlushE = 1'b0;
        drive(1'b0, 32'd0);
        checks++;
        if (Count !== 3'd0 || ValidD !== 1'b0 || PCD !== 32'd0 || Empty !== 1'b1) begin
            errors++;
            $display("FAIL flush got cnt=%0d v=%b pc=%h e=%b exp 0 0 0 1", Count, ValidD, PCD, Empty);
        end
        StallD = 1'b0;
        step();
        checks++;
        if (ValidD !== 1'b0 || PCD !== 32'd0) begin
            errors++;
            $display("FAIL flush_after got v=%b pc=%h exp 0 0", ValidD, PCD);
        end
    endtask

    task automatic test_async_reset();
        StallD = 1'b1;
        drive(1'b1, 32'd40);
        step();
        drive(1'b1, 32'd44);
        step();
        drive(1'b0, 32'd0);
        checks++;
        if (Count !== 3'd2) begin
            errors++;
            $display("FAIL areset_pre got cnt=%0d exp 2", Count);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (Empty !== 1'b1 || ValidD !== 1'b0 || Count !== 3'd0 || PCD !== 32'd0) begin
            errors++;
            $display("FAIL areset_mid got e=%b v=%b cnt=%0d pc=%h exp 1 0 0 0", Empty, ValidD, Count, PCD);
        end
        drive(1'b1, 32'd100);
        step();
        rst = 1'b1;
        step();
        drive(1'b0, 32'd0);
        checks++;
        if (PCD !== 32'd100 || Count !== 3'd1 || ValidD !== 1'b1) begin
            errors++;
            $display("FAIL areset_push got pc=%0d cnt=%0d v=%b exp 100 1 1", PCD, Count, ValidD);
        end
    endtask

    task automatic test_full_pop_no_push();
        StallD = 1'b1;
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 32'(100 + 4 * i));
            step();
        end
        checks++;
        if (Full !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_pre got f=%b exp 1", Full);
        end
        StallD = 1'b0;
        drive(1'b1, 32'd116);
        step();
        checks++;
        if (Count !== 3'd3 || PCD !== 32'd104 || ReadyF !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_pop got cnt=%0d pc=%0d r=%b exp 3 104 1", Count, PCD, ReadyF);
        end
        step();
        drive(1'b0, 32'd0);
        checks++;
        if (Count !== 3'd3 || PCD !== 32'd108) begin
            errors++;
            $display("FAIL fullpop_both got cnt=%0d pc=%0d exp 3 108", Count, PCD);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (PCD !== 32'(108 + 4 * i)) begin
                errors++;
                $display("FAIL fullpop_drain[%0d] got pc=%0d exp %0d", i, PCD, 108 + 4 * i);
            end
            step();
        end
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_empty got e=%b exp 1", Empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_stalled();
        test_full();
        test_stream();
        test_flush();
        test_async_reset();
        test_full_pop_no_push();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
